// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer/size/response encodings, slave FSM states and the byte-enable helper
package ahb_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
`ifdef AHB_SLV_WAIT_EN
        , ST_WAIT
`endif
    } state_e;

    function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr_lo);
        return size == HSIZE_BYTE ? 4'b0001 << addr_lo :
               size == HSIZE_HALF ? 4'b0011 << addr_lo : 4'b1111;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// ahb_sram_bank: word array with synchronous read, byte-enabled write and same-edge write-to-read merge
module ahb_sram_bank #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] merged;

    // read view of the addressed word, with lanes committing on this same edge taking the new bytes
    always_comb begin
        merged = mem_q[raddr_i];
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b] && waddr_i == raddr_i) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end

    // lane-masked write port
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    // read word captured at the accept edge and held through the data phase
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= merged;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: zero-wait AHB-Lite SRAM slave with two-cycle ERROR; AHB_SLV_WAIT_EN adds WAIT_CYCLES wait states
module ahb_lite_sram_slave import ahb_pkg::*; #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MEM_DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] off;
    logic              acc, take, legal, commit;
    logic [31:0]       rdata;
    logic              unused_ok;

`ifdef AHB_SLV_WAIT_EN
    localparam int     CW    = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam state_e ST_GO = WAIT_CYCLES == 0 ? ST_DATA : ST_WAIT;
    logic [CW-1:0] cnt_q, cnt_d;
    assign HREADYOUT = state_q != ST_ERR1 && state_q != ST_WAIT;
`else
    localparam state_e ST_GO = ST_DATA;
    assign HREADYOUT = state_q != ST_ERR1;
`endif

    assign unused_ok = ^{HBURST, HPROT, WAIT_CYCLES[0]};

    assign off    = HADDR - BASE_ADDR;
    assign acc    = HSEL && HREADY && (htrans_e'(HTRANS) == NONSEQ || htrans_e'(HTRANS) == SEQ);
    assign take   = acc && HREADYOUT;
    assign legal  = off < ADDR_W'(4 * MEM_DEPTH) && HSIZE <= HSIZE_WORD &&
                    !(HSIZE == HSIZE_HALF && HADDR[0]) &&
                    !(HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign commit = ARESETN && state_q == ST_DATA && write_q;

    // next state and data-phase capture; IDLE, DATA and ERR2 all complete a beat and may accept the next
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        be_d    = be_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
                state_d = cnt_q == '0 ? ST_DATA : ST_WAIT;
                cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: begin
                state_d = !take ? ST_IDLE : legal ? ST_GO : ST_ERR1;
                if (take) begin
                    addr_d  = off[AW+1:2];
                    write_d = HWRITE;
                    be_d    = be_from_size(HSIZE, HADDR[1:0]);
`ifdef AHB_SLV_WAIT_EN
                    cnt_d   = CW'(WAIT_CYCLES - 1);
`endif
                end
            end
        endcase
    end

    // state and data-phase registers; reset abandons any pending beat
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            be_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            be_q    <= be_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    ahb_sram_bank #(.DEPTH(MEM_DEPTH)) u_bank (
        .clk     (ACLK),
        .we_i    (commit),
        .waddr_i (addr_q),
        .be_i    (be_q),
        .wdata_i (HWDATA[31:0]),
        .re_i    (ARESETN && take && legal && !HWRITE),
        .raddr_i (off[AW+1:2]),
        .rdata_o (rdata)
    );

    assign HRESP  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA = (state_q == ST_DATA && !write_q) ? DATA_W'(rdata) : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: randomized pipelined AHB traffic checked against a behavioural memory model
module tb_ahb_lite_sram_slave;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif

    logic        ACLK = 1'b0, ARESETN = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0, HRDATA;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = '0, HBURST = '0;
    logic [3:0]  HPROT = '0;
    logic        HREADY, HREADYOUT, HRESP;

    assign HREADY = HREADYOUT;
    always #5 ACLK = ~ACLK;

    ahb_lite_sram_slave #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(WC)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] mem_m [DEPTH];
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        xfer_t t;
        t.sel = 1'b1; t.trans = 2'd2; t.wr = wr; t.size = size; t.addr = addr; t.data = data;
        q.push_back(t);
    endtask

    function automatic bit legal_m(input xfer_t t);
        return t.addr < 32'(4 * DEPTH) && t.size <= 3'd2 && t.addr % (32'd1 << t.size) == 0;
    endfunction

    function automatic void wr_m(input xfer_t t);
        int lo = int'(t.addr[1:0]);
        int n  = 1 << t.size;
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n) mem_m[t.addr[11:2]][8*b +: 8] = t.data[8*b +: 8];
    endfunction

    task automatic run();
        xfer_t dp, ap;
        dp = '{default: 0};
        ap = '{default: 0};
        q.push_back(ap);
        while (q.size() > 0) begin
            bit act, ok;
            int last;
            ap = q.pop_front();
            HSEL = ap.sel; HTRANS = ap.trans; HWRITE = ap.wr; HSIZE = ap.size; HADDR = ap.addr;
            HWDATA = dp.data;
            act  = dp.sel && dp.trans[1];
            ok   = legal_m(dp);
            last = !act ? 0 : ok ? W : 1;
            for (int k = 0; k <= last; k++) begin
                @(negedge ACLK);
                chk($sformatf("hreadyout@%h/%0d", dp.addr, k), 32'(HREADYOUT), 32'(k == last));
                if (act) chk($sformatf("hresp@%h/%0d", dp.addr, k), 32'(HRESP), 32'(!ok));
                if (k == last && act && !dp.wr)
                    chk($sformatf("hrdata@%h", dp.addr), HRDATA, ok ? mem_m[dp.addr[11:2]] : 32'h0);
                @(posedge ACLK); #1;
            end
            if (act && ok && dp.wr) wr_m(dp);
            dp = ap;
        end
    endtask

    initial begin
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;

        for (int i = 0; i < 4; i++) push(1'b1, 3'd2, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) push(1'b0, 3'd2, 32'(4 * i), 32'h0);
        run();

        push(1'b1, 3'd2, 32'h10, 32'hAABBCCDD);
        push(1'b1, 3'd0, 32'h12, 32'h005A0000);
        push(1'b0, 3'd2, 32'h10, 32'h0);
        push(1'b1, 3'd1, 32'h12, 32'h12340000);
        push(1'b0, 3'd2, 32'h10, 32'h0);
        push(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
        push(1'b0, 3'd2, 32'h20, 32'h0);
        run();

        for (int w = 0; w < 32; w++) push(1'b1, 3'd2, 32'(4 * w), $urandom);
        for (int w = DEPTH - 4; w < DEPTH; w++) push(1'b1, 3'd2, 32'(4 * w), $urandom);
        run();

        push(1'b1, 3'd2, 32'(4 * DEPTH), 32'hDEADBEEF);
        push(1'b0, 3'd2, 32'h2, 32'h0);
        push(1'b0, 3'd2, 32'h0, 32'h0);
        run();

        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h30;
        @(posedge ACLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = 32'h0BAD0BAD; ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("midrst_hresp", 32'(HRESP), 32'h0);
        chk("midrst_hrdata", HRDATA, 32'h0);
        @(posedge ACLK); #1;
        push(1'b0, 3'd2, 32'h30, 32'h0);
        run();

        for (int i = 0; i < 400; i++) begin
            xfer_t t;
            int r = $urandom_range(0, 9);
            int s;
            t.sel   = $urandom_range(0, 9) != 0;
            t.trans = $urandom_range(0, 4) == 0 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            t.wr    = 1'($urandom_range(0, 1));
            t.size  = $urandom_range(0, 7) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            s       = t.size > 3'd2 ? 0 : int'(t.size);
            t.addr  = r < 7 ? 32'(4 * $urandom_range(0, 31)) :
                      r < 9 ? 32'(4 * $urandom_range(DEPTH - 4, DEPTH - 1)) :
                      $urandom_range(0, 1) == 1 ? 32'(4 * DEPTH + 4 * $urandom_range(0, 15)) :
                      32'hFFFFFFF0 + 32'(4 * $urandom_range(0, 3));
            t.addr  = t.addr + ($urandom_range(0, 5) == 0 ? 32'($urandom_range(0, 3)) :
                                32'(($urandom_range(0, 3) >> s) << s));
            t.data  = $urandom;
            q.push_back(t);
        end
        run();

        push(1'b1, 3'd2, 32'h4, 32'h2);
        push(1'b0, 3'd2, 32'h4, 32'h0);
        run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
